// File: rtl/hmc_sys_pkg.sv
// Shared types and constants for the HMC system-interface reset sequencer.
// Holds the sequencer state encoding, the counter-width helper and the parameter defaults.
package hmc_sys_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } seq_state_t;

  localparam int DEF_NUM_DOM      = 2;
  localparam int DEF_MIN_ASSERT   = 8;
  localparam int DEF_DEASSERT_GAP = 16;
  localparam int DEF_DIV_W        = 4;

  // The counter must be able to hold the release edge of the last domain.
  function automatic int seq_cnt_w(input int num_dom, input int min_assert,
                                   input int deassert_gap);
    return $clog2(min_assert + (num_dom - 1) * deassert_gap + 1);
  endfunction

endpackage

// File: rtl/hmc_clk_en_div.sv
// Per-domain clock-enable divider: one pulse every ratio+1 cycles while the domain runs.
// The counter is parked at zero whenever the domain is not running.
module hmc_clk_en_div #(
  parameter int DIV_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rel_i,
  input  logic [DIV_W-1:0] ratio_i,
  output logic             clk_en_o
);

  logic [DIV_W-1:0] cnt_q;

  // Wrapping on >= keeps the counter bounded if the ratio shrinks mid-count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      clk_en_o <= 1'b0;
    end else if (!rel_i) begin
      cnt_q    <= '0;
      clk_en_o <= 1'b0;
    end else if (cnt_q >= ratio_i) begin
      cnt_q    <= '0;
      clk_en_o <= 1'b1;
    end else begin
      cnt_q    <= cnt_q + DIV_W'(1);
      clk_en_o <= 1'b0;
    end
  end

endmodule

// File: rtl/hmc_reset_sequencer.sv
// Reset-and-clock-enable sequencer: holds all domains in reset, releases them in order,
// then runs a clock-enable divider per released domain; supports soft re-sequencing.
module hmc_reset_sequencer
  import hmc_sys_pkg::*;
#(
  parameter int NUM_DOM      = DEF_NUM_DOM,
  parameter int MIN_ASSERT   = DEF_MIN_ASSERT,
  parameter int DEASSERT_GAP = DEF_DEASSERT_GAP,
  parameter int DIV_W        = DEF_DIV_W
) (
  input  logic                     clk_hmc,
  input  logic                     res_hmc,
  input  logic                     soft_req,
  output logic                     soft_ack,
  input  logic [NUM_DOM*DIV_W-1:0] div_ratio,
  output logic [NUM_DOM-1:0]       res_n_dom,
  output logic [NUM_DOM-1:0]       clk_en_dom,
  output logic                     seq_done,
  output logic                     busy
);

  localparam int CNT_MAX = MIN_ASSERT + (NUM_DOM - 1) * DEASSERT_GAP;
  localparam int CNT_W   = seq_cnt_w(NUM_DOM, MIN_ASSERT, DEASSERT_GAP);

  seq_state_t         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last_hit;
  logic               first_hit;
  logic [NUM_DOM-1:0] rel_hit;
  logic [NUM_DOM-1:0] res_n_d;
  logic [NUM_DOM-1:0] dom_run;

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign first_hit = (cnt_inc == CNT_W'(MIN_ASSERT));
  assign last_hit  = (cnt_inc == CNT_W'(CNT_MAX));

  always_comb begin
    res_n_d = res_n_dom;
    case (state_q)
      ASSERT, RELEASE: res_n_d = res_n_dom | rel_hit;
      DONE:            if (soft_req) res_n_d = '0;
      default:         res_n_d = '0;
    endcase
  end

  // A domain only runs its divider while it is released now and stays released on this
  // edge, so clk_en drops together with res_n on a soft re-sequence.
  assign dom_run = res_n_dom & res_n_d;

  always_ff @(posedge clk_hmc or posedge res_hmc) begin
    if (res_hmc) begin
      state_q   <= ASSERT;
      cnt_q     <= '0;
      res_n_dom <= '0;
      soft_ack  <= 1'b0;
      seq_done  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      res_n_dom <= res_n_d;
      soft_ack  <= 1'b0;
      case (state_q)
        ASSERT: begin
          cnt_q <= cnt_inc;
          if (first_hit) begin
            if (last_hit) begin
              state_q  <= DONE;
              seq_done <= 1'b1;
              busy     <= 1'b0;
            end else begin
              state_q <= RELEASE;
            end
          end
        end
        RELEASE: begin
          cnt_q <= cnt_inc;
          if (last_hit) begin
            state_q  <= DONE;
            seq_done <= 1'b1;
            busy     <= 1'b0;
          end
        end
        DONE: begin
          if (soft_req) begin
            state_q  <= ASSERT;
            cnt_q    <= '0;
            soft_ack <= 1'b1;
            seq_done <= 1'b0;
            busy     <= 1'b1;
          end
        end
        default: begin
          state_q <= ASSERT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
    assign rel_hit[i] = (cnt_inc == CNT_W'(MIN_ASSERT + i * DEASSERT_GAP));

    hmc_clk_en_div #(
      .DIV_W(DIV_W)
    ) u_div (
      .clk_i   (clk_hmc),
      .rst_i   (res_hmc),
      .rel_i   (dom_run[i]),
      .ratio_i (div_ratio[i*DIV_W +: DIV_W]),
      .clk_en_o(clk_en_dom[i])
    );
  end

endmodule

// File: tb/tb_hmc_reset_sequencer.sv
// Scoreboard bench for hmc_reset_sequencer: a timeline model predicts every cycle's outputs.
module tb_hmc_reset_sequencer;

  localparam int NUM_DOM      = 2;
  localparam int MIN_ASSERT   = 8;
  localparam int DEASSERT_GAP = 16;
  localparam int DIV_W        = 4;
  localparam int RW           = NUM_DOM * DIV_W;
  localparam int LAST         = MIN_ASSERT + (NUM_DOM - 1) * DEASSERT_GAP;

  logic                clk_hmc  = 1'b0;
  logic                res_hmc  = 1'b1;
  logic                soft_req = 1'b0;
  logic [RW-1:0]       div_ratio = {4'd3, 4'd0};
  logic                soft_ack;
  logic [NUM_DOM-1:0]  res_n_dom;
  logic [NUM_DOM-1:0]  clk_en_dom;
  logic                seq_done;
  logic                busy;

  int errors = 0;
  int checks = 0;
  int t_seq  = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [NUM_DOM-1:0] rn;
    logic [NUM_DOM-1:0] en;
    logic               ack;
    logic               done;
    logic               busy;
  } obs_t;

  obs_t exp_q[$];

  always #5 clk_hmc = ~clk_hmc;

  hmc_reset_sequencer #(
    .NUM_DOM     (NUM_DOM),
    .MIN_ASSERT  (MIN_ASSERT),
    .DEASSERT_GAP(DEASSERT_GAP),
    .DIV_W       (DIV_W)
  ) dut (
    .clk_hmc   (clk_hmc),
    .res_hmc   (res_hmc),
    .soft_req  (soft_req),
    .soft_ack  (soft_ack),
    .div_ratio (div_ratio),
    .res_n_dom (res_n_dom),
    .clk_en_dom(clk_en_dom),
    .seq_done  (seq_done),
    .busy      (busy)
  );

  // Outputs t edges into a sequence: domain i is out of reset from its release edge on,
  // and its enable fires every ratio+1 edges counted from that release edge.
  function automatic obs_t predict(input int t, input logic ack, input logic [RW-1:0] ratios);
    obs_t o;
    int   rel;
    int   r;
    o.ack  = ack;
    o.done = (t >= LAST);
    o.busy = !(t >= LAST);
    for (int i = 0; i < NUM_DOM; i++) begin
      rel     = MIN_ASSERT + i * DEASSERT_GAP;
      r       = int'(ratios[i*DIV_W +: DIV_W]);
      o.rn[i] = (t >= rel);
      o.en[i] = (t > rel) && (((t - rel) % (r + 1)) == 0);
    end
    return o;
  endfunction

  always @(posedge clk_hmc) begin
    obs_t e;
    cyc++;
    if (res_hmc) begin
      t_seq = 0;
      e = predict(0, 1'b0, div_ratio);
    end else if (t_seq >= LAST && soft_req) begin
      t_seq = 0;
      e = predict(0, 1'b1, div_ratio);
    end else begin
      t_seq++;
      e = predict(t_seq, 1'b0, div_ratio);
    end
    exp_q.push_back(e);
  end

  always @(negedge clk_hmc) begin
    obs_t a;
    obs_t e;
    a = {res_n_dom, clk_en_dom, soft_ack, seq_done, busy};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty cycle=%0d actual rn=%b en=%b ack=%b done=%b busy=%b",
               cyc, a.rn, a.en, a.ack, a.done, a.busy);
    end else begin
      e = exp_q.pop_front();
      if (a !== e)
        begin
          errors++;
          $display("FAIL cycle_outputs cycle=%0d actual rn=%b en=%b ack=%b done=%b busy=%b expected rn=%b en=%b ack=%b done=%b busy=%b",
                   cyc, a.rn, a.en, a.ack, a.done, a.busy, e.rn, e.en, e.ack, e.done, e.busy);
        end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_hmc);
      #7;
    end
  endtask

  task automatic check_async(input string tag);
    logic [2*NUM_DOM+2:0] a;
    logic [2*NUM_DOM+2:0] e;
    a = {res_n_dom, clk_en_dom, soft_ack, seq_done, busy};
    e = {{(2*NUM_DOM){1'b0}}, 3'b001};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL async_reset_%s actual=%b expected=%b", tag, a, e);
    end
  endtask

  task automatic do_reset(input string tag, input int hold);
    res_hmc = 1'b1;
    #1;
    check_async(tag);
    step(hold);
    res_hmc = 1'b0;
  endtask

  initial begin
    // Power-on with default ratios, then a single-cycle soft request once done.
    step(3);
    res_hmc = 1'b0;
    step(40);
    soft_req = 1'b1;
    step(1);
    soft_req = 1'b0;
    step(40);

    // Request held across ASSERT/RELEASE must be ignored.
    do_reset("ignored", 2);
    step(2);
    soft_req = 1'b1;
    step(18);
    soft_req = 1'b0;
    step(30);

    // Reset in the middle of the release sequence.
    do_reset("pre_mid", 2);
    step(15);
    do_reset("mid_seq", 2);
    step(40);

    // Request tied high: back-to-back sequences.
    soft_req = 1'b1;
    step(130);
    soft_req = 1'b0;
    step(30);

    // Randomized ratios (changed only under reset), soft pulses and occasional resets.
    for (int k = 0; k < 6; k++) begin
      res_hmc = 1'b1;
      #1;
      check_async("rand_entry");
      div_ratio = RW'($urandom);
      step(2);
      res_hmc = 1'b0;
      for (int c = 0; c < 150; c++) begin
        soft_req = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 199) == 0) begin
          do_reset("rand_mid", 1);
        end
        step(1);
      end
      soft_req = 1'b0;
    end

    step(1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
